// File: rtl/rv_lsu.sv
// Load/store unit for an in-order RV32 pipeline. It issues one data-memory access
// at a time over a req/gnt + rvalid bus and stalls the pipeline until the access completes.
module rv_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_re,
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rdata_valid,
    output logic            o_misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            is_mem;
    logic            legal;
    logic            aligned;
    logic            accept;
    logic [3:0]      store_be;
    logic [XLEN-1:0] store_wdata;
    logic [XLEN-1:0] rdata_shifted;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_word;

    // Request decode is only meaningful while idle; reset masks it so every output is quiet.
    always_comb begin
        is_mem = i_rst_n & i_valid & (i_re | i_we) & (state_q == ST_IDLE);
        if (i_we) begin
            legal = ~i_funct3[2] & (i_funct3[1:0] != 2'b11);
        end else begin
            legal = (i_funct3[1:0] != 2'b11) & ~(i_funct3[2] & i_funct3[1]);
        end
        case (i_funct3[1:0])
            2'b01:   aligned = ~i_addr[0];
            2'b10:   aligned = (i_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept       = is_mem & legal & aligned;
        o_misaligned = is_mem & legal & ~aligned;
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << i_addr[1:0];
                store_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                store_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = i_wdata;
            end
        endcase
    end

    // Lane select uses the latched address, since i_addr may already belong to the next instruction.
    always_comb begin
        rdata_shifted = i_dmem_rdata >> {addr_q[1:0], 3'b000};
        load_byte     = rdata_shifted[7:0];
        load_half     = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_word = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_word = {24'd0, load_byte};
            3'b001:  load_word = {{16{load_half[15]}}, load_half};
            3'b101:  load_word = {16'd0, load_half};
            default: load_word = i_dmem_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        o_stall  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_REQ;
                    addr_d   = i_addr;
                    we_d     = i_we;
                    funct3_d = i_funct3;
                    be_d     = store_be;
                    wdata_d  = store_wdata;
                    o_stall  = 1'b1;
                end
            end
            ST_REQ: begin
                o_stall = 1'b1;
                if (i_dmem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = load_word;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        o_dmem_req    = (state_q == ST_REQ);
        o_dmem_we     = (state_q == ST_REQ) & we_q;
        o_dmem_addr   = {addr_q[XLEN-1:2], 2'b00};
        o_dmem_be     = be_q;
        o_dmem_wdata  = wdata_q;
        o_rdata       = rdata_q;
        o_rdata_valid = (state_q == ST_DONE) & ~we_q;
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed table, corner-case sequences (reset mid-access,
// back-to-back accesses) and randomized transactions checked against a byte-level model.
module tb_rv_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_re, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_rdata;
    logic        o_rdata_valid, o_misaligned;

    rv_lsu #(.XLEN(32)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_re          (i_re),
        .i_we          (i_we),
        .i_funct3      (i_funct3),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_be     (o_dmem_be),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_misaligned  (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_acc;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cur_txn = 0;
    logic [31:0] last_rd = 32'd0;
    int          st_gnts = 0;
    int          ld_gnts = 0;
    vec_t        tbl[$];

    always @(posedge i_clk) begin
        if (o_dmem_req && i_dmem_gnt) begin
            if (o_dmem_we) st_gnts++;
            else           ld_gnts++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn %0d %s: got 0x%08h expected 0x%08h", cur_txn, name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gd, input int rd,
                                input logic acc, input logic mis, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rexp);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_dly = gd; v.rv_dly = rd;
        v.exp_acc = acc; v.exp_mis = mis; v.exp_be = be; v.exp_wd = wd; v.exp_rd = rexp;
        return v;
    endfunction

    // Reference model: access size in bytes, legality, byte lanes and extension from first principles.
    function automatic int m_size(input logic [2:0] f3);
        logic [1:0] sz;
        sz = f3[1:0];
        return 1 << sz;
    endfunction

    function automatic bit m_legal(input logic re, input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        if (re) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return 1'b0;
    endfunction

    function automatic bit m_aligned(input logic [31:0] addr, input logic [2:0] f3);
        return (addr % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
        logic [3:0] be;
        int         lane;
        be = 4'b0000;
        for (int i = 0; i < m_size(f3); i++) begin
            lane = int'(addr % 4) + i;
            if (lane < 4) be[lane] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [2:0] f3);
        logic [63:0] v, mask;
        int          nbits;
        nbits = 8 * m_size(f3);
        mask  = (64'd1 << nbits) - 64'd1;
        v     = {32'd0, rd} >> (8 * (addr % 4));
        v     = v & mask;
        if (!f3[2] && nbits < 32 && v[nbits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_txn(input vec_t t);
        logic [31:0] exp_addr;
        exp_addr = t.addr & 32'hFFFF_FFFC;
        i_valid  = 1'b1;
        i_re     = t.re;
        i_we     = t.we;
        i_funct3 = t.f3;
        i_addr   = t.addr;
        i_wdata  = t.wdata;
        @(negedge i_clk);
        check("idle_misaligned", o_misaligned, t.exp_mis);
        check("idle_stall", o_stall, t.exp_acc);
        check("idle_req", o_dmem_req, 1'b0);
        if (!t.exp_acc) begin
            tick;
            i_valid       = 1'b0;
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = $urandom;
            @(negedge i_clk);
            check("rej_req", o_dmem_req, 1'b0);
            check("rej_stall", o_stall, 1'b0);
            tick;
            i_dmem_rvalid = 1'b0;
            @(negedge i_clk);
            check("rej_rdata_valid", o_rdata_valid, 1'b0);
            check("rej_rdata_hold", o_rdata, last_rd);
            tick;
            return;
        end
        tick;
        for (int k = 0; k <= t.gnt_dly; k++) begin
            i_dmem_gnt    = (k == t.gnt_dly);
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = $urandom;
            @(negedge i_clk);
            check("req_req", o_dmem_req, 1'b1);
            check("req_stall", o_stall, 1'b1);
            check("req_addr", o_dmem_addr, exp_addr);
            check("req_we", o_dmem_we, t.we);
            if (t.we) begin
                check("req_be", o_dmem_be, t.exp_be);
                check("req_wdata", o_dmem_wdata, t.exp_wd);
            end
            tick;
        end
        i_dmem_gnt = 1'b0;
        for (int k = 0; k <= t.rv_dly; k++) begin
            i_dmem_rvalid = (k == t.rv_dly);
            i_dmem_rdata  = (k == t.rv_dly) ? t.rdata : $urandom;
            @(negedge i_clk);
            check("wait_stall", o_stall, 1'b1);
            check("wait_req", o_dmem_req, 1'b0);
            check("wait_rdata_valid", o_rdata_valid, 1'b0);
            tick;
        end
        i_dmem_rvalid = 1'b0;
        if (!t.we) last_rd = t.exp_rd;
        @(negedge i_clk);
        check("done_rdata_valid", o_rdata_valid, !t.we);
        check("done_rdata", o_rdata, last_rd);
        check("done_stall", o_stall, 1'b0);
        check("done_req", o_dmem_req, 1'b0);
        tick;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("after_rdata_valid", o_rdata_valid, 1'b0);
        check("after_rdata_hold", o_rdata, last_rd);
        check("after_req", o_dmem_req, 1'b0);
        tick;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0; i_re = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_wdata = 32'd0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;

        //      re  we  f3    addr          wdata          rdata          gd rd acc mis be       wd             rd
        tbl.push_back(mk(1, 0, 3'd0, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 0, 1, 0, 4'b0001, 32'h0,         32'hFFFF_FF80));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,         3, 0, 1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0));
        tbl.push_back(mk(1, 0, 3'd5, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0, 3, 1, 0, 4'b1100, 32'h0,         32'h0000_8001));
        tbl.push_back(mk(1, 0, 3'd4, 32'h0000_0103, 32'h0,         32'h80FF_0000, 1, 1, 1, 0, 4'b1000, 32'h0,         32'h0000_0080));
        tbl.push_back(mk(1, 0, 3'd1, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 0, 2, 1, 0, 4'b1100, 32'h0,         32'hFFFF_8001));
        tbl.push_back(mk(1, 0, 3'd5, 32'h0000_0000, 32'h0,         32'h8001_7FFF, 2, 0, 1, 0, 4'b0011, 32'h0,         32'h0000_7FFF));
        tbl.push_back(mk(1, 0, 3'd2, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 0, 0, 1, 0, 4'b1111, 32'h0,         32'hDEAD_BEEF));
        tbl.push_back(mk(1, 0, 3'd0, 32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 1, 1, 0, 4'b0010, 32'h0,         32'h0000_007F));
        tbl.push_back(mk(0, 1, 3'd0, 32'h0000_0101, 32'h1234_5678, 32'h0,         1, 0, 1, 0, 4'b0010, 32'h7878_7878, 32'h0));
        tbl.push_back(mk(0, 1, 3'd2, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         0, 2, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0));
        tbl.push_back(mk(1, 1, 3'd0, 32'h0000_0003, 32'h0000_00A5, 32'h0,         0, 0, 1, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0));
        tbl.push_back(mk(1, 0, 3'd2, 32'h0000_0105, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 3'd1, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 3'd2, 32'h0000_0102, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 3'd3, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 3'd6, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 3'd2, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0));

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_stall", o_stall, 1'b0);
        check("rst_req", o_dmem_req, 1'b0);
        check("rst_we", o_dmem_we, 1'b0);
        check("rst_addr", o_dmem_addr, 32'd0);
        check("rst_be", o_dmem_be, 4'd0);
        check("rst_wdata", o_dmem_wdata, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_rdata_valid", o_rdata_valid, 1'b0);
        check("rst_misaligned", o_misaligned, 1'b0);
        i_rst_n = 1'b1;
        tick;

        foreach (tbl[i]) begin
            cur_txn = i;
            run_txn(tbl[i]);
        end

        // Reset while waiting for a load response, with the response arriving after reset.
        cur_txn = 1000;
        i_valid = 1'b1; i_re = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_0500;
        tick;
        i_dmem_gnt = 1'b1;
        tick;
        i_dmem_gnt = 1'b0;
        @(negedge i_clk);
        check("wrst_wait_stall", o_stall, 1'b1);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check("wrst_stall", o_stall, 1'b0);
        check("wrst_req", o_dmem_req, 1'b0);
        check("wrst_addr", o_dmem_addr, 32'd0);
        check("wrst_be", o_dmem_be, 4'd0);
        check("wrst_wdata", o_dmem_wdata, 32'd0);
        check("wrst_rdata", o_rdata, 32'd0);
        check("wrst_rdata_valid", o_rdata_valid, 1'b0);
        tick;
        i_rst_n       = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hFFFF_FFFF;
        last_rd       = 32'd0;
        @(negedge i_clk);
        check("wrst_late_stall", o_stall, 1'b0);
        check("wrst_late_req", o_dmem_req, 1'b0);
        tick;
        i_dmem_rvalid = 1'b0;
        @(negedge i_clk);
        check("wrst_late_rdata_valid", o_rdata_valid, 1'b0);
        check("wrst_late_rdata", o_rdata, 32'd0);
        check("wrst_late_stall2", o_stall, 1'b0);
        tick;

        // Store followed immediately by a load held on i_valid.
        cur_txn = 2000;
        begin
            int st0, ld0;
            st0 = st_gnts;
            ld0 = ld_gnts;
            i_valid = 1'b1; i_re = 1'b0; i_we = 1'b1; i_funct3 = 3'd2;
            i_addr = 32'h0000_0400; i_wdata = 32'h1122_3344;
            @(negedge i_clk);
            check("b2b_sw_stall", o_stall, 1'b1);
            tick;
            i_dmem_gnt = 1'b1;
            @(negedge i_clk);
            check("b2b_sw_we", o_dmem_we, 1'b1);
            tick;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1;
            tick;
            i_dmem_rvalid = 1'b0;
            i_re = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0404;
            @(negedge i_clk);
            check("b2b_done_stall", o_stall, 1'b0);
            check("b2b_done_req", o_dmem_req, 1'b0);
            check("b2b_done_rdata_valid", o_rdata_valid, 1'b0);
            tick;
            @(negedge i_clk);
            check("b2b_lw_accept_stall", o_stall, 1'b1);
            check("b2b_lw_accept_req", o_dmem_req, 1'b0);
            tick;
            i_dmem_gnt = 1'b1;
            @(negedge i_clk);
            check("b2b_lw_req", o_dmem_req, 1'b1);
            check("b2b_lw_we", o_dmem_we, 1'b0);
            check("b2b_lw_addr", o_dmem_addr, 32'h0000_0404);
            tick;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5566_7788;
            tick;
            i_dmem_rvalid = 1'b0; i_valid = 1'b0;
            @(negedge i_clk);
            check("b2b_lw_rdata_valid", o_rdata_valid, 1'b1);
            check("b2b_lw_rdata", o_rdata, 32'h5566_7788);
            last_rd = 32'h5566_7788;
            tick;
            tick;
            check("b2b_store_grants", st_gnts - st0, 1);
            check("b2b_load_grants", ld_gnts - ld0, 1);
        end

        // Randomized transactions against the model.
        for (int n = 0; n < 400; n++) begin
            vec_t        v;
            int          kind;
            logic        re, we, lg;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd;
            cur_txn = 3000 + n;
            kind = $urandom_range(0, 9);
            re   = (kind != 0) && (kind < 6);
            we   = (kind == 1) || (kind >= 6);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            lg   = m_legal(re, we, f3);
            v = mk(re, we, f3, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                   lg && m_aligned(addr, f3), lg && !m_aligned(addr, f3),
                   lg ? m_be(addr, f3) : 4'b0000, lg ? m_wdata(wd, f3) : 32'd0,
                   lg ? m_load(rd, addr, f3) : 32'd0);
            run_txn(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  EX/MEM memory instruction present; held stable by upstream while o_stall=1.
REQ-005 i_re / i_we  input  1 each  load / store; both high SHALL be treated as store.
REQ-006 i_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores.
REQ-007 i_addr  input  XLEN  effective address, the ALU result.
REQ-008 i_wdata  input  XLEN  store data (rs2).
REQ-009 o_stall  output  1  freeze upstream pipeline stages.
REQ-010 o_dmem_req, o_dmem_we  output  1 each  bus request; write qualifier.
REQ-011 o_dmem_addr  output  XLEN  word address, bits [1:0] forced to 0.
REQ-012 o_dmem_be  output  4  byte enables; o_dmem_wdata  output  XLEN  lane-replicated store data.
REQ-013 i_dmem_gnt, i_dmem_rvalid  input  1 each  request accepted; response (load data or store ack).
REQ-014 i_dmem_rdata  input  XLEN  raw word read data.
REQ-015 o_rdata  output  XLEN  aligned, extended load result; o_rdata_valid  output  1  one-cycle qualifier.
REQ-016 o_misaligned  output  1  misaligned-access flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE, i_valid & (i_re|i_we) & aligned & legal funct3 -> latch addr, we, funct3, be, wdata; go to REQ.
REQ-019 REQ: o_dmem_req=1 with latched fields; stay until i_dmem_gnt=1, then go to WAIT; req/addr/we/be/wdata SHALL stay stable while ungranted.
REQ-020 WAIT: on i_dmem_rvalid go to DONE, registering the extracted load word; i_dmem_rvalid SHALL be ignored in every other state.
REQ-021 DONE: o_rdata_valid=1 for loads only (0 for stores), o_stall=0, i_valid ignored, next state IDLE unconditionally.
REQ-022 o_stall = (IDLE & accept) | REQ | WAIT; low in DONE and in IDLE with no accept.
REQ-023 Min load latency: accept cycle 0, gnt cycle 1, rvalid cycle 2, o_rdata_valid cycle 3; o_stall high cycles 0-2.
REQ-024 Alignment: H/HU/SH need addr[0]=0; W/SW need addr[1:0]=00; bytes always aligned.
REQ-025 Misaligned in IDLE: o_misaligned=1 combinationally that cycle, no bus request, o_stall=0, state remains IDLE.
REQ-026 Illegal funct3 (011, 110, 111, and 1xx stores): no access, no stall, o_misaligned=0.
REQ-027 Store be: B = 0001<<addr[1:0]; H = 0011<<(2*addr[1]); W = 1111.
REQ-028 Store wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-029 Load extraction: select byte/halfword at latched addr offset; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-030 o_rdata SHALL hold its last value when o_rdata_valid=0.
REQ-031 i_valid with neither i_re nor i_we SHALL be ignored.

Reset
REQ-032 i_rst_n=0 SHALL immediately force IDLE and zero every output and latched register.
REQ-033 Reset mid-access (REQ or WAIT) SHALL abandon the transaction; a late i_dmem_rvalid after reset is ignored.

Verification
REQ-034 LB addr 0x103, rdata 0x80FF_0000, gnt/rvalid immediate -> be n/a, o_rdata 0xFFFF_FF80 in cycle 3, stall cycles 0-2.
REQ-035 SH addr 0x202, wdata 0x1234_ABCD, gnt delayed 3 cycles -> addr 0x200, be 1100, wdata 0xABCD_ABCD held stable; o_rdata_valid never set.
REQ-036 LW addr 0x105 -> o_misaligned=1 same cycle, o_dmem_req=0, o_stall=0.
REQ-037 LHU addr 0x002, rdata 0x8001_7FFF, rvalid 4 cycles after gnt -> o_rdata 0x0000_8001, stall until DONE.
REQ-038 i_rst_n low while in WAIT, rvalid next cycle -> state IDLE, all outputs 0, no o_rdata_valid.
REQ-039 Back-to-back SW then LW held on i_valid -> second access accepted the cycle after DONE, no duplicate store.
